srx_receiver_param: RTL
=======================

Name: srx_receiver_param

Overview:
Parametrised serial receive engine; successor to the fixed-format serial reception FSM. Integrates an oversampled bit timer, a shift register, configurable parity and stop bits, a holding register with `dry`/`ack` handshake, and error flags. Sits between the pad synchroniser and the host register interface. An external baud generator supplies `tick` at OVS times the bit rate.

Parameters:
- DATA_W, 8: data bits per frame, 5..16, sent LSB first.
- OVS, 16: ticks per bit; even, at least 4.
- PAR_MODE, 1: parity mode. 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk, in, 1: clock. All logic updates on the rising edge.
- rst, in, 1: synchronous reset, active-low.
- en, in, 1: receiver enable.
- tick, in, 1: oversample strobe, one clk wide.
- rxd, in, 1: serial line, already synchronised. Idles high.
- ack, in, 1: host consumed `data_out`.
- data_out, out, DATA_W: last received frame.
- dry, out, 1: data ready.
- err_par, out, 1: parity error on the held frame.
- err_frm, out, 1: stop bit sampled low on the held frame.
- ovr, out, 1: overrun, sticky.
- busy, out, 1: frame in progress.

Behaviour:
- Reset (`rst`=0 at a clk edge): state=IDLE, counters=0, shift register=0. Outputs `data_out`=0, `dry`=0, `err_par`=0, `err_frm`=0, `ovr`=0, `busy`=0.
- All state and counter activity advances only on clk edges with `tick`=1 and `en`=1.
- `en`=0: state forced to IDLE, counters cleared, any frame in progress discarded silently. Holding register and flags are retained. `ack` is still honoured.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `rxd`=0 on a tick moves to START with phase counter=0.
  - Phase counter: counts 0..OVS-1 per bit and wraps.
  - Sample point: phase OVS/2. With SRX_MAJORITY_EN defined, the decision point is OVS/2+1 instead.
- START: at the decision point, sampled 1 means false start; return to IDLE with no flags set. Sampled 0 means the start bit is valid; on phase wrap go to DATA.
- DATA: sample bit k into shift position k, k = 0..DATA_W-1. After the last bit wraps, go to PARITY if PAR_MODE≠0, otherwise to STOP.
- PARITY: compute XOR of the data bits and the sampled parity bit.
  - Even mode: result 1 means parity error.
  - Odd mode: result 0 means parity error.
- STOP: sample each of the STOP_BITS stop bits; any stop sample of 0 sets the framing-error candidate. At the last stop bit's decision point, complete the frame and go directly to IDLE (do not wait for phase wrap), so a back-to-back start edge is accepted.
- Frame completion, the same edge as the last stop decision:
  - If `dry`=0, or `ack`=1 in that cycle: load `data_out`, `err_par`, `err_frm` from this frame; set `dry`=1.
  - Otherwise (`dry`=1 and no `ack`): discard the frame; `data_out` and the error flags are unchanged; `ovr`=1.
- `ack`=1 (any cycle, no completion in the same cycle): `dry`, `err_par`, `err_frm` and `ovr` all go to 0 on the next edge.
  - When `ack` and completion coincide, completion wins: `dry` stays 1, new data is loaded, `ovr` is cleared.
- `busy` is 1 whenever state≠IDLE. It is registered and rises on the edge that enters START.
- Latency: `dry` is high on the clk edge carrying the last stop-bit decision tick.
- Reset asserted mid-frame: full reset on the next edge; no partial data is delivered.

Optional Feature:
- Macro: SRX_MAJORITY_EN.
- Defined: every bit (start, data, parity, stop) takes samples at phases OVS/2-1, OVS/2 and OVS/2+1. The bit value is the 2-of-3 majority, decided at OVS/2+1.
- Not defined: a single sample at phase OVS/2, with no sample storage registers.

Test Plan:
All scenarios use DATA_W=8, OVS=16, PAR_MODE=1, STOP_BITS=1, `tick` every 4 clks.
1. Frame 0xA5 with parity 0, stop 1 → `data_out`=0xA5, `dry`=1 at the stop decision tick, `err_par`=`err_frm`=0. Then `ack` pulse → `dry`=0 on the next clk.
2. Frame 0x3C with parity bit 1 → `data_out`=0x3C, `err_par`=1, `err_frm`=0.
3. Frame 0x55 with stop bit 0 → `err_frm`=1, `dry`=1. A following valid 0x12 frame plus `ack` clears both flags.
4. `rxd` low for 4 ticks, then high → `busy` pulses, then returns to 0; `dry` stays 0; no flags.
5. Frames 0x11 then 0x22 with no `ack` → `data_out`=0x11, `ovr`=1. `ack` coinciding with a third frame 0x33 → `data_out`=0x33, `dry`=1, `ovr`=0.
6. `rst`=0 during data bit 4 → all outputs 0 on the next edge; a subsequent clean 0xA5 frame is received correctly.
   - With SRX_MAJORITY_EN: a 1-tick glitch at phase OVS/2 of data bit 0 is rejected.

Source files
------------

// File: rtl/srx_receiver_param.sv
`default_nettype none
// ============================================================================
//  Module   : srx_receiver_param
//  Brief    : Parametrised oversampled serial receiver with holding register,
//             dry/ack handshake, parity/framing/overrun flags.
//             Define SRX_MAJORITY_EN for 2-of-3 majority bit sampling.
//  Revision : 1.0 - initial release
// ============================================================================
module srx_receiver_param #(
    parameter int DATA_W    = 8,
    parameter int OVS       = 16,
    parameter int PAR_MODE  = 1,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tick,
    input  logic              rxd,
    input  logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic              dry,
    output logic              err_par,
    output logic              err_frm,
    output logic              ovr,
    output logic              busy
);

    localparam int c_PW = $clog2(OVS);
    localparam int c_BW = $clog2(DATA_W);

    localparam logic [c_PW-1:0] c_WRAP      = c_PW'(OVS - 1);
`ifdef SRX_MAJORITY_EN
    localparam logic [c_PW-1:0] c_S0        = c_PW'(OVS / 2 - 1);
    localparam logic [c_PW-1:0] c_S1        = c_PW'(OVS / 2);
    localparam logic [c_PW-1:0] c_DEC       = c_PW'(OVS / 2 + 1);
`else
    localparam logic [c_PW-1:0] c_DEC       = c_PW'(OVS / 2);
`endif
    localparam logic [c_BW-1:0] c_LAST_DATA = c_BW'(DATA_W - 1);
    localparam logic [c_BW-1:0] c_LAST_STOP = c_BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [c_PW-1:0]   r_phase;
    logic [c_PW-1:0]   w_phase_nx;
    logic [c_BW-1:0]   r_bitcnt;
    logic [c_BW-1:0]   w_bitcnt_nx;
    logic [DATA_W-1:0] r_shift;
    logic              r_parbit;
    logic              r_frm;
    logic              r_busy;
    logic [DATA_W-1:0] r_data;
    logic              r_dry;
    logic              r_err_par;
    logic              r_err_frm;
    logic              r_ovr;

    logic              w_bit;
    logic              w_dec;
    logic              w_wrap;
    logic              w_start;
    logic              w_complete;
    logic              w_par_err;
    logic              w_frm_final;

    assign w_dec  = (r_phase == c_DEC);
    assign w_wrap = (r_phase == c_WRAP);

`ifdef SRX_MAJORITY_EN
    logic r_s0;
    logic r_s1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else if (en && tick) begin
            if (r_phase == c_S0) r_s0 <= rxd;
            if (r_phase == c_S1) r_s1 <= rxd;
        end
    end

    // The third sample is the live line at the decision phase.
    assign w_bit = (r_s0 & r_s1) | (r_s0 & rxd) | (r_s1 & rxd);
`else
    assign w_bit = rxd;
`endif

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_phase_nx  = r_phase;
        w_bitcnt_nx = r_bitcnt;
        w_start     = 1'b0;
        w_complete  = 1'b0;
        if (!en) begin
            w_state_nx  = S_IDLE;
            w_phase_nx  = '0;
            w_bitcnt_nx = '0;
        end else if (tick) begin
            w_phase_nx = w_wrap ? '0 : r_phase + 1'b1;
            case (r_state)
                S_IDLE: begin
                    w_phase_nx  = '0;
                    w_bitcnt_nx = '0;
                    if (!rxd) begin
                        w_state_nx = S_START;
                        w_start    = 1'b1;
                    end
                end
                S_START: begin
                    if (w_dec && w_bit) begin
                        w_state_nx = S_IDLE;
                        w_phase_nx = '0;
                    end else if (w_wrap) begin
                        w_state_nx = S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_wrap) begin
                        if (r_bitcnt == c_LAST_DATA) begin
                            w_bitcnt_nx = '0;
                            w_state_nx  = (PAR_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            w_bitcnt_nx = r_bitcnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_wrap) w_state_nx = S_STOP;
                end
                S_STOP: begin
                    // Leave at the decision point so a back-to-back start edge is seen.
                    if (w_dec && (r_bitcnt == c_LAST_STOP)) begin
                        w_complete  = 1'b1;
                        w_state_nx  = S_IDLE;
                        w_phase_nx  = '0;
                        w_bitcnt_nx = '0;
                    end else if (w_wrap) begin
                        w_bitcnt_nx = r_bitcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nx  = S_IDLE;
                    w_phase_nx  = '0;
                    w_bitcnt_nx = '0;
                end
            endcase
        end
    end

    generate
        if (PAR_MODE == 1) begin : g_par_even
            assign w_par_err = ^r_shift ^ r_parbit;
        end else if (PAR_MODE == 2) begin : g_par_odd
            assign w_par_err = ~(^r_shift ^ r_parbit);
        end else begin : g_par_none
            assign w_par_err = 1'b0;
        end
    endgenerate

    assign w_frm_final = r_frm | ~w_bit;

    // ------------------------------------------------------------------
    // State, datapath and holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_parbit  <= 1'b0;
            r_frm     <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_dry     <= 1'b0;
            r_err_par <= 1'b0;
            r_err_frm <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_phase  <= w_phase_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_busy   <= (w_state_nx != S_IDLE);

            if (en && tick) begin
                if (w_start) r_frm <= 1'b0;
                if (w_dec) begin
                    case (r_state)
                        S_DATA:   r_shift[r_bitcnt] <= w_bit;
                        S_PARITY: r_parbit <= w_bit;
                        S_STOP:   if (!w_bit) r_frm <= 1'b1;
                        default:  ;
                    endcase
                end
            end

            // A completing frame takes priority over a same-cycle ack.
            if (w_complete) begin
                if (!r_dry || ack) begin
                    r_data    <= r_shift;
                    r_err_par <= w_par_err;
                    r_err_frm <= w_frm_final;
                    r_dry     <= 1'b1;
                    if (ack) r_ovr <= 1'b0;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (ack) begin
                r_dry     <= 1'b0;
                r_err_par <= 1'b0;
                r_err_frm <= 1'b0;
                r_ovr     <= 1'b0;
            end
        end
    end

    assign data_out = r_data;
    assign dry      = r_dry;
    assign err_par  = r_err_par;
    assign err_frm  = r_err_frm;
    assign ovr      = r_ovr;
    assign busy     = r_busy;

endmodule
`default_nettype wire
